weight_load_sequencer: RTL
==========================

// Module: weight_load_sequencer
// PURPOSE
//  Controller that streams the quantized model file into on-chip weight memory.
//  Consumes a byte stream (little-endian u32 header fields, then weight/bias bytes).
//  Parses the per-layer geometry and writes a layer descriptor table.
//  Generates sequential weight-memory write addresses.
//  Sits between the file/DMA byte source and the weight RAM plus descriptor regfile.
// PARAMETERS
//  MAX_LAYERS    10    max layers accepted; desc index width LW=$clog2(MAX_LAYERS)
//  MAX_NEURONS   1024  max rows/cols per layer; dim width DW=$clog2(MAX_NEURONS+1)
//  WEIGHT_WIDTH  8     weight/bias byte width; only 8 is legal
//  ADDR_WIDTH    16    weight-memory address width
// PORTS
//  clk         in   1    clock, all logic on rising edge
//  rst_n       in   1    synchronous active-low reset
//  start       in   1    1-cycle pulse: begin parse; ignored while busy
//  byte_valid  in   1    source byte valid
//  byte_data   in   8    source byte
//  byte_ready  out  1    sequencer accepts byte (beat = valid & ready)
//  mem_we      out  1    weight RAM write strobe
//  mem_addr    out  AW   weight RAM write address
//  mem_wdata   out  WW   weight RAM write data
//  desc_we     out  1    descriptor write strobe
//  desc_idx    out  LW   layer index
//  desc_rows   out  DW   layer rows
//  desc_cols   out  DW   layer cols
//  desc_base   out  AW   layer base address in weight RAM
//  busy        out  1    parse in progress
//  done        out  1    sticky success flag, cleared on next accepted start
//  error       out  1    sticky failure flag, cleared on next accepted start
//  err_code    out  3    0 none, 1 bad layer count, 2 bad dim, 3 addr overflow
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; addr pointer 0.
//  Reset asserted mid-parse aborts immediately; no further mem_we/desc_we.
//  Stream format: NL(u32); then NL times: ROWS(u32), COLS(u32),
//   ROWS*COLS weight bytes (row-major), then ROWS bias bytes.
//  FSM states: IDLE -> HDR_NL -> HDR_ROWS -> HDR_COLS -> CHECK -> WEIGHTS -> BIASES;
//   BIASES -> HDR_ROWS while layer < NL-1; otherwise BIASES -> DONE.
//   Any check failure -> ERR.
//  byte_ready=1 only in HDR_*, WEIGHTS, BIASES. Low in CHECK (1 cycle), IDLE, DONE, ERR.
//  u32 fields assemble LSB first over 4 beats; the FSM advances on the 4th beat.
//  Checks:
//   - NL==0 or NL>MAX_LAYERS -> err 1 (checked after NL).
//   - rows/cols ==0 or >MAX_NEURONS -> err 2 (checked in CHECK).
//   - base+rows*cols+rows > 2^AW -> err 3 (checked in CHECK).
//   - Use a 33-bit compare; no wrap.
//  desc_we: 1-cycle pulse in the cycle after CHECK passes.
//   Fields: idx=layer, rows, cols, base=current ptr.
//  Weight/bias beats: mem_we/addr/wdata registered, asserted the cycle after the beat.
//   ptr increments per beat; biases follow weights contiguously.
//  Next layer base = previous base + rows*cols + rows.
//  Gaps in byte_valid: stall with no writes; the counters hold.
//  DONE/ERR: done or error set together with busy=0. Both states are terminal until start.
//   Extra bytes in DONE/ERR are not consumed.
//  start in DONE/ERR: clear flags and err_code, ptr=0, go to HDR_NL. busy=1 from next cycle.
//  Row/col counters are DW wide. The beat counter is AW+1 wide.
// STRUCTURE
//  model_pkg: err code localparams, FSM state encoding, header field width (32).
//  Sub-module le_word_assembler: 4-beat byte->u32 shifter with beat count and word_valid.
//  Remaining logic (FSM, checks, counters) lives in this module.
// TESTING
//  1) NL=1, rows=2, cols=3, weights A0..A5, biases B0 B1 -> one desc_we (0,2,3,0);
//     mem writes addr 0..7 = A0..A5,B0,B1; done=1.
//  2) NL=2: layer0 2x3, layer1 1x2 -> second desc base=8; writes addr 8..10; done=1.
//  3) NL=0 -> error=1, err_code=1, no desc_we, byte_ready=0 afterwards.
//  4) rows=1025 -> err_code=2. With AW=4 and a 4x4 layer -> err_code=3. No mem_we in either.
//  5) byte_valid toggled randomly at 50% -> identical write sequence to scenario 1.
//  6) rst_n low during WEIGHTS beat 3 -> outputs 0 next cycle.
//     Fresh start replays scenario 1 cleanly.

Source files
------------

// File: rtl/weight_load_sequencer_pkg.sv
// Shared types for the weight loader: error codes, FSM encoding, header field width.
package weight_load_sequencer_pkg;

    localparam int HDR_W = 32;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_LAYERS = 3'd1;
    localparam logic [2:0] ERR_DIM    = 3'd2;
    localparam logic [2:0] ERR_OVF    = 3'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_NL,
        S_HDR_ROWS,
        S_HDR_COLS,
        S_CHECK,
        S_WEIGHTS,
        S_BIASES,
        S_DONE,
        S_ERR
    } state_t;

    // Header fields are checked at full 32-bit width so large values cannot alias into range.
    function automatic logic out_of_range(input logic [HDR_W-1:0] v, input logic [HDR_W-1:0] max_v);
        return (v == '0) || (v > max_v);
    endfunction

endpackage

// File: rtl/weight_load_sequencer_le_word_assembler.sv
// Little-endian byte-to-u32 assembler for header fields.
// Latency: word_valid is combinational on the 4th accepted beat.
// Backpressure: none of its own; it only counts beats the parent accepts.
module le_word_assembler
    import weight_load_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             beat,
    input  logic [7:0]       byte_data,
    output logic [HDR_W-1:0] word,
    output logic             word_valid
);

    logic [1:0]  beat_cnt;
    logic [23:0] lo_bytes;

    // Earlier bytes shift down so the first byte ends up in bits [7:0].
    assign word       = {byte_data, lo_bytes};
    assign word_valid = beat && (beat_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= 2'd0;
            lo_bytes <= '0;
        end else if (clear) begin
            beat_cnt <= 2'd0;
            lo_bytes <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 2'd1;
            lo_bytes <= {byte_data, lo_bytes[23:8]};
        end
    end

endmodule

// File: rtl/weight_load_sequencer.sv
// Parses the quantized model byte stream into descriptor-table and weight-RAM writes.
// Latency: mem/desc writes are registered, one cycle after the beat / CHECK state.
// Backpressure: byte_ready only in header and data states; gaps in byte_valid stall everything.
module weight_load_sequencer
    import weight_load_sequencer_pkg::*;
#(
    parameter  int MAX_LAYERS   = 10,
    parameter  int MAX_NEURONS  = 1024,
    parameter  int WEIGHT_WIDTH = 8,
    parameter  int ADDR_WIDTH   = 16,
    localparam int LW           = $clog2(MAX_LAYERS),
    localparam int DW           = $clog2(MAX_NEURONS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic                    byte_ready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WEIGHT_WIDTH-1:0] mem_wdata,
    output logic                    desc_we,
    output logic [LW-1:0]           desc_idx,
    output logic [DW-1:0]           desc_rows,
    output logic [DW-1:0]           desc_cols,
    output logic [ADDR_WIDTH-1:0]   desc_base,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [2:0]              err_code
);

    state_t              state;
    logic [LW:0]         nl_r;
    logic [LW-1:0]       layer;
    logic [DW-1:0]       rows_r;
    logic [DW-1:0]       cols_r;
    logic [DW-1:0]       row_cnt;
    logic [ADDR_WIDTH:0] ptr;
    logic [ADDR_WIDTH:0] beat_cnt;
    logic [ADDR_WIDTH:0] w_total;
    logic                dim_bad;

    logic [HDR_W-1:0]    word;
    logic                word_valid;
    logic                hdr_st;
    logic                data_st;
    logic                hdr_beat;
    logic                data_beat;
    logic                start_acc;
    logic [2*DW-1:0]     prod;
    logic [32:0]         need;
    logic                ovf;

    assign hdr_st     = (state == S_HDR_NL) || (state == S_HDR_ROWS) || (state == S_HDR_COLS);
    assign data_st    = (state == S_WEIGHTS) || (state == S_BIASES);
    assign byte_ready = hdr_st || data_st;
    assign hdr_beat   = byte_valid && hdr_st;
    assign data_beat  = byte_valid && data_st;
    assign start_acc  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    // ptr carries one extra bit so a layer that exactly fills the RAM is not seen as base 0.
    assign prod = (2*DW)'(rows_r) * (2*DW)'(cols_r);
    assign need = 33'(ptr) + 33'(prod) + 33'(rows_r);
    assign ovf  = need > (33'd1 << ADDR_WIDTH);

    le_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_acc),
        .beat       (hdr_beat),
        .byte_data  (byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            nl_r      <= '0;
            layer     <= '0;
            rows_r    <= '0;
            cols_r    <= '0;
            row_cnt   <= '0;
            ptr       <= '0;
            beat_cnt  <= '0;
            w_total   <= '0;
            dim_bad   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            desc_we   <= 1'b0;
            desc_idx  <= '0;
            desc_rows <= '0;
            desc_cols <= '0;
            desc_base <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            mem_we  <= 1'b0;
            desc_we <= 1'b0;

            if (data_beat) begin
                mem_we    <= 1'b1;
                mem_addr  <= ptr[ADDR_WIDTH-1:0];
                mem_wdata <= WEIGHT_WIDTH'(byte_data);
                ptr       <= ptr + (ADDR_WIDTH+1)'(1);
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_HDR_NL;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        err_code <= ERR_NONE;
                        ptr      <= '0;
                        layer    <= '0;
                    end
                end
                S_HDR_NL: begin
                    if (word_valid) begin
                        if (out_of_range(word, HDR_W'(MAX_LAYERS))) begin
                            state    <= S_ERR;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_LAYERS;
                        end else begin
                            nl_r  <= word[LW:0];
                            state <= S_HDR_ROWS;
                        end
                    end
                end
                S_HDR_ROWS: begin
                    if (word_valid) begin
                        rows_r  <= word[DW-1:0];
                        dim_bad <= out_of_range(word, HDR_W'(MAX_NEURONS));
                        state   <= S_HDR_COLS;
                    end
                end
                S_HDR_COLS: begin
                    if (word_valid) begin
                        cols_r  <= word[DW-1:0];
                        dim_bad <= dim_bad | out_of_range(word, HDR_W'(MAX_NEURONS));
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (dim_bad || ovf) begin
                        state    <= S_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= dim_bad ? ERR_DIM : ERR_OVF;
                    end else begin
                        desc_we   <= 1'b1;
                        desc_idx  <= layer;
                        desc_rows <= rows_r;
                        desc_cols <= cols_r;
                        desc_base <= ptr[ADDR_WIDTH-1:0];
                        w_total   <= (ADDR_WIDTH+1)'(prod);
                        beat_cnt  <= '0;
                        row_cnt   <= '0;
                        state     <= S_WEIGHTS;
                    end
                end
                S_WEIGHTS: begin
                    if (data_beat) begin
                        beat_cnt <= beat_cnt + (ADDR_WIDTH+1)'(1);
                        if (beat_cnt == w_total - (ADDR_WIDTH+1)'(1)) begin
                            state <= S_BIASES;
                        end
                    end
                end
                S_BIASES: begin
                    if (data_beat) begin
                        row_cnt <= row_cnt + DW'(1);
                        if (row_cnt == rows_r - DW'(1)) begin
                            if ({1'b0, layer} == nl_r - (LW+1)'(1)) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                layer <= layer + LW'(1);
                                state <= S_HDR_ROWS;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
